// File: rtl/updown_counter_if.sv
// rtl/updown_counter_if.sv - control/status bundle for the modulo up/down counter
interface updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             terminal;
  logic             carry;

  // master drives the requests and observes the counter state
  modport master (
    output enable,
    output up,
    output load,
    output load_value,
    input  count,
    input  terminal,
    input  carry
  );

  // slave is the counter itself
  modport slave (
    input  enable,
    input  up,
    input  load,
    input  load_value,
    output count,
    output terminal,
    output carry
  );
endinterface

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - modulo-MODULUS up/down counter, wraps at bounds (saturates when UPDOWN_COUNTER_SAT_EN is defined)
module updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic             at_top;
  logic             at_bottom;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_next;

  assign at_top    = (count_q == MAX_COUNT);
  assign at_bottom = (count_q == ZERO);

  // bound flag for the current direction; enable deliberately not included
  assign at_bound  = bus.up ? at_top : at_bottom;

  // out-of-range load values collapse to the top state so count stays legal
  always_comb begin
    load_clamped = bus.load_value;
    if (32'(bus.load_value) >= 32'(MODULUS)) begin
      load_clamped = MAX_COUNT;
    end
  end

  // value the count takes if an enabled step happens this edge
  always_comb begin
    step_next = count_q;
    if (bus.up) begin
      if (at_top) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        step_next = MAX_COUNT;
`else
        step_next = ZERO;
`endif
      end else begin
        step_next = count_q + ONE;
      end
    end else begin
      if (at_bottom) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        step_next = ZERO;
`else
        step_next = MAX_COUNT;
`endif
      end else begin
        step_next = count_q - ONE;
      end
    end
  end

  // count/carry registers: reset beats load beats enable, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= ZERO;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      carry_q <= 1'b0;
    end else if (bus.enable) begin
      count_q <= step_next;
      carry_q <= at_bound;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.terminal = at_bound;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - scoreboard bench for updown_counter (wrap and saturating builds)
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int tag;
    int count;
    bit carry;
    bit terminal;
  } exp_t;

  logic clock;
  logic reset_a;
  logic reset_b;

  updown_counter_if #(.WIDTH(4)) a_if ();
  updown_counter_if #(.WIDTH(3)) b_if ();

  updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (a_if.slave)
  );

  updown_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (b_if.slave)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   vectors;
  int   miscompares;
  int   tag_a;
  int   tag_b;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input exp_t e, input int c, input bit cy, input bit t);
    vectors++;
    if (c != e.count || cy != e.carry || t != e.terminal) begin
      miscompares++;
      $display("FAIL %s#%0d: got count=%0d carry=%0d terminal=%0d, expected count=%0d carry=%0d terminal=%0d",
               name, e.tag, c, cy, t, e.count, e.carry, e.terminal);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      check("mod10", e, int'(a_if.count), a_if.carry, a_if.terminal);
    end
  end

  always @(posedge clock) begin
    #1;
    if (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      check("mod8", e, int'(b_if.count), b_if.carry, b_if.terminal);
    end
  end

  task automatic a_step(input bit rst, input bit ld, input int lv, input bit en, input bit u,
                        input int ec, input bit ecy, input bit et);
    exp_t e;
    @(negedge clock);
    reset_a = rst;
    a_if.load = ld;
    a_if.load_value = 4'(lv);
    a_if.enable = en;
    a_if.up = u;
    tag_a++;
    e.tag = tag_a; e.count = ec; e.carry = ecy; e.terminal = et;
    qa.push_back(e);
  endtask

  task automatic b_step(input bit rst, input bit ld, input int lv, input bit en, input bit u,
                        input int ec, input bit ecy, input bit et);
    exp_t e;
    @(negedge clock);
    reset_b = rst;
    b_if.load = ld;
    b_if.load_value = 3'(lv);
    b_if.enable = en;
    b_if.up = u;
    tag_b++;
    e.tag = tag_b; e.count = ec; e.carry = ecy; e.terminal = et;
    qb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0; tag_a = 0; tag_b = 0;
    reset_a = 1'b1; reset_b = 1'b1;
    a_if.load = 0; a_if.load_value = 0; a_if.enable = 0; a_if.up = 0;
    b_if.load = 0; b_if.load_value = 0; b_if.enable = 0; b_if.up = 0;

    // reset state; reset overrides load and enable
    a_step(1, 0, 0, 0, 0, 0, 0, 1);
    a_step(1, 1, 7, 1, 1, 0, 0, 0);

    // count up twelve edges through the wrap
    for (int i = 1; i <= 9; i++) a_step(0, 0, 0, 1, 1, i, 0, i == 9);
    a_step(0, 0, 0, 1, 1, SAT ? 9 : 0, 1, SAT);
    a_step(0, 0, 0, 1, 1, SAT ? 9 : 1, SAT, SAT);
    a_step(0, 0, 0, 1, 1, SAT ? 9 : 2, SAT, SAT);

    // count down from reset
    a_step(1, 0, 0, 0, 0, 0, 0, 1);
    a_step(0, 0, 0, 1, 0, SAT ? 0 : 9, 1, SAT);
    a_step(0, 0, 0, 1, 0, SAT ? 0 : 8, SAT, SAT);
    a_step(0, 0, 0, 1, 0, SAT ? 0 : 7, SAT, SAT);

    // clamped load ignores enable/up, then step off the top
    a_step(0, 1, 13, 1, 0, 9, 0, 0);
    a_step(0, 0, 0, 1, 1, SAT ? 9 : 0, 1, SAT);
    a_step(0, 1, 10, 0, 1, 9, 0, 1);
    a_step(0, 1, 0, 0, 0, 0, 0, 1);

    // hold with enable low
    a_step(0, 1, 5, 0, 1, 5, 0, 0);
    a_step(0, 0, 0, 0, 1, 5, 0, 0);
    a_step(0, 0, 0, 0, 0, 5, 0, 0);
    a_step(0, 0, 0, 0, 1, 5, 0, 0);
    a_step(0, 0, 0, 0, 0, 5, 0, 0);

    // reset and load together
    a_step(1, 1, 5, 1, 1, 0, 0, 0);

    // direction change takes effect immediately
    a_step(0, 1, 5, 0, 0, 5, 0, 0);
    a_step(0, 0, 0, 1, 0, 4, 0, 0);
    a_step(0, 0, 0, 1, 1, 5, 0, 0);
    a_step(0, 0, 0, 1, 0, 4, 0, 0);

    // reset mid-count discards the step, first edge after counts normally
    a_step(1, 0, 0, 1, 1, 0, 0, 0);
    a_step(0, 0, 0, 1, 1, 1, 0, 0);
    a_step(0, 0, 0, 0, 1, 1, 0, 0);

    // full binary range: WIDTH=3, MODULUS=8
    b_step(1, 0, 0, 0, 1, 0, 0, 0);
    b_step(0, 1, 7, 1, 1, 7, 0, 1);
    b_step(0, 0, 0, 1, 1, SAT ? 7 : 0, 1, SAT);
    b_step(1, 0, 0, 0, 0, 0, 0, 1);
    b_step(0, 0, 0, 1, 0, SAT ? 0 : 7, 1, SAT);
    b_step(0, 1, 3, 0, 1, 3, 0, 0);
    b_step(0, 0, 0, 1, 1, 4, 0, 0);
    b_step(0, 0, 0, 1, 0, 3, 0, 0);
    b_step(0, 0, 0, 1, 1, 4, 0, 0);
    b_step(0, 0, 0, 1, 1, 5, 0, 0);
    b_step(0, 0, 0, 1, 1, 6, 0, 0);
    b_step(0, 0, 0, 1, 1, 7, 0, 1);
    b_step(0, 0, 0, 0, 1, 7, 0, 1);

    repeat (3) @(posedge clock);
    #2;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
